// File: rtl/pong_match_referee_pkg.sv
// Shared types and defaults for the pong match referee: FSM states, geometry
// defaults, side encodings for serve_dir/winner.
package pong_match_referee_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SERVE     = 2'd1,
        ST_RALLY     = 2'd2,
        ST_GAME_OVER = 2'd3
    } ref_state_e;

    localparam int unsigned DEF_X_W           = 10;
    localparam int unsigned DEF_SCORE_W       = 8;
    localparam int unsigned DEF_WIN_SCORE     = 11;
    localparam int unsigned DEF_FIELD_W       = 640;
    localparam int unsigned DEF_LEFT_PADDLE_X = 10;
    localparam int unsigned DEF_PADDLE_W      = 10;
    localparam int unsigned DEF_PADDLE_H      = 80;
    localparam int unsigned DEF_SERVE_FRAMES  = 60;
    localparam int unsigned DEF_SPEEDUP_HITS  = 4;
    localparam int unsigned SPEED_W           = 2;

    // Shared by serve_dir and winner
    localparam logic SIDE_LEFT  = 1'b0;
    localparam logic SIDE_RIGHT = 1'b1;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pong_match_referee_if.sv
// Game-side bus of the match referee: positions and buttons in, referee
// decisions and scores out.
interface pong_match_referee_if #(
    parameter int unsigned X_W     = 10,
    parameter int unsigned SCORE_W = 8
);
    logic               frame_tick;
    logic [X_W-1:0]     ball_x;
    logic [X_W-1:0]     ball_y;
    logic [X_W-1:0]     left_paddle_y;
    logic [X_W-1:0]     right_paddle_y;
    logic               left_start;
    logic               right_start;
    logic               hit_left;
    logic               hit_right;
    logic               new_round;
    logic               ball_run;
    logic               serve_dir;
    logic [SCORE_W-1:0] left_score;
    logic [SCORE_W-1:0] right_score;
    logic               game_over;
    logic               winner;
    logic [1:0]         speed_level;

    modport master (
        output frame_tick, ball_x, ball_y, left_paddle_y, right_paddle_y,
               left_start, right_start,
        input  hit_left, hit_right, new_round, ball_run, serve_dir,
               left_score, right_score, game_over, winner, speed_level
    );

    modport slave (
        input  frame_tick, ball_x, ball_y, left_paddle_y, right_paddle_y,
               left_start, right_start,
        output hit_left, hit_right, new_round, ball_run, serve_dir,
               left_score, right_score, game_over, winner, speed_level
    );
endinterface

// File: rtl/pong_paddle_hit_detect.sv
// Combinational ball-on-paddle-face test; one face per instance, compared in
// X_W+1 bits so paddle_y+PADDLE_H cannot overflow.
module pong_paddle_hit_detect #(
    parameter int unsigned X_W      = 10,
    parameter int unsigned FACE_X   = 10,
    parameter bit          FACE_LE  = 1'b1,
    parameter int unsigned PADDLE_H = 80
) (
    input  logic [X_W-1:0] ball_x,
    input  logic [X_W-1:0] ball_y,
    input  logic [X_W-1:0] paddle_y,
    output logic           hit_c
);
    localparam int unsigned XE_W = X_W + 1;
    localparam logic [XE_W-1:0] FACE = XE_W'(FACE_X);
    localparam logic [XE_W-1:0] PH   = XE_W'(PADDLE_H);

    logic [XE_W-1:0] bx_e;
    logic [XE_W-1:0] by_e;
    logic [XE_W-1:0] top_e;
    logic [XE_W-1:0] bot_e;
    logic            x_ok;
    logic            y_ok;

    assign bx_e  = {1'b0, ball_x};
    assign by_e  = {1'b0, ball_y};
    assign top_e = {1'b0, paddle_y};
    assign bot_e = top_e + PH;

    assign x_ok  = FACE_LE ? (bx_e <= FACE) : (bx_e >= FACE);
    assign y_ok  = (by_e >= top_e) && (by_e <= bot_e);
    assign hit_c = x_ok && y_ok;
endmodule

// File: rtl/pong_match_referee.sv
// Pong match referee: hit/exit detection, saturating scores, serve/rally FSM
// with win detection. Define REFEREE_SPEEDUP_EN to build the hit-driven speed steps.
module pong_match_referee
    import pong_match_referee_pkg::*;
#(
    parameter int unsigned X_W           = DEF_X_W,
    parameter int unsigned SCORE_W       = DEF_SCORE_W,
    parameter int unsigned WIN_SCORE     = DEF_WIN_SCORE,
    parameter int unsigned FIELD_W       = DEF_FIELD_W,
    parameter int unsigned LEFT_PADDLE_X = DEF_LEFT_PADDLE_X,
    parameter int unsigned PADDLE_W      = DEF_PADDLE_W,
    parameter int unsigned PADDLE_H      = DEF_PADDLE_H,
    parameter int unsigned SERVE_FRAMES  = DEF_SERVE_FRAMES,
    parameter int unsigned SPEEDUP_HITS  = DEF_SPEEDUP_HITS
) (
    input  logic                 clk,
    input  logic                 reset,
    pong_match_referee_if.slave  bus
);
    localparam int unsigned XE_W  = X_W + 1;
    localparam int unsigned CNT_W = cnt_width(SERVE_FRAMES);

    localparam logic [XE_W-1:0]    FIELD_X    = XE_W'(FIELD_W);
    localparam logic [XE_W-1:0]    QUARTER_X  = XE_W'(FIELD_W / 4);
    localparam logic [XE_W-1:0]    THREEQ_X   = XE_W'((3 * FIELD_W) / 4);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

    ref_state_e         state;
    ref_state_e         state_d;
    logic               left_start_q;
    logic               right_start_q;
    logic               start_edge;
    logic [X_W-1:0]     prev_x;
    logic [CNT_W-1:0]   serve_cnt;
    logic [CNT_W-1:0]   serve_cnt_d;
    logic [SCORE_W-1:0] left_score_q;
    logic [SCORE_W-1:0] right_score_q;
    logic [SCORE_W-1:0] left_score_d;
    logic [SCORE_W-1:0] right_score_d;
    logic [SCORE_W-1:0] left_inc;
    logic [SCORE_W-1:0] right_inc;
    logic               serve_dir_q;
    logic               serve_dir_d;
    logic               winner_q;
    logic               winner_d;
    logic               new_round_q;
    logic               new_round_d;
    logic               ball_run_q;
    logic               game_over_q;
    logic               hit_left_q;
    logic               hit_right_q;
    logic               hit_left_c;
    logic               hit_right_c;
    logic               left_exit;
    logic               right_exit;
    logic               serve_done;
    logic [XE_W-1:0]    ball_x_e;
    logic [XE_W-1:0]    prev_x_e;

    pong_paddle_hit_detect #(
        .X_W(X_W), .FACE_X(LEFT_PADDLE_X), .FACE_LE(1'b1), .PADDLE_H(PADDLE_H)
    ) u_hit_left (
        .ball_x(bus.ball_x), .ball_y(bus.ball_y),
        .paddle_y(bus.left_paddle_y), .hit_c(hit_left_c)
    );

    pong_paddle_hit_detect #(
        .X_W(X_W), .FACE_X(FIELD_W - PADDLE_W), .FACE_LE(1'b0), .PADDLE_H(PADDLE_H)
    ) u_hit_right (
        .ball_x(bus.ball_x), .ball_y(bus.ball_y),
        .paddle_y(bus.right_paddle_y), .hit_c(hit_right_c)
    );

    assign start_edge = (bus.left_start & ~left_start_q) | (bus.right_start & ~right_start_q);

    // A wrapped position (>= FIELD_W) plus the side it came from decides the exit
    assign ball_x_e   = {1'b0, bus.ball_x};
    assign prev_x_e   = {1'b0, prev_x};
    assign left_exit  = bus.frame_tick && (state == ST_RALLY) &&
                        (prev_x_e < QUARTER_X) && (ball_x_e >= FIELD_X);
    assign right_exit = bus.frame_tick && (state == ST_RALLY) && !left_exit &&
                        (prev_x_e >= THREEQ_X) && (ball_x_e >= FIELD_X);
    assign serve_done = bus.frame_tick && (state == ST_SERVE) && (serve_cnt == SERVE_LAST);

    assign left_inc  = (left_score_q  == WIN) ? left_score_q  : left_score_q  + SCORE_W'(1);
    assign right_inc = (right_score_q == WIN) ? right_score_q : right_score_q + SCORE_W'(1);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            left_start_q  <= 1'b0;
            right_start_q <= 1'b0;
            prev_x        <= '0;
            serve_cnt     <= '0;
            left_score_q  <= '0;
            right_score_q <= '0;
            serve_dir_q   <= SIDE_LEFT;
            winner_q      <= SIDE_LEFT;
            new_round_q   <= 1'b1;
            ball_run_q    <= 1'b0;
            game_over_q   <= 1'b0;
            hit_left_q    <= 1'b0;
            hit_right_q   <= 1'b0;
        end else begin
            state         <= state_d;
            left_start_q  <= bus.left_start;
            right_start_q <= bus.right_start;
            if (bus.frame_tick) begin
                prev_x <= bus.ball_x;
            end
            serve_cnt     <= serve_cnt_d;
            left_score_q  <= left_score_d;
            right_score_q <= right_score_d;
            serve_dir_q   <= serve_dir_d;
            winner_q      <= winner_d;
            new_round_q   <= new_round_d;
            ball_run_q    <= (state_d == ST_RALLY);
            game_over_q   <= (state_d == ST_GAME_OVER);
            hit_left_q    <= hit_left_c  && (state == ST_RALLY);
            hit_right_q   <= hit_right_c && (state == ST_RALLY);
        end
    end

    // Next state
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (start_edge) state_d = ST_SERVE;
            end
            ST_SERVE: begin
                if (serve_done) state_d = ST_RALLY;
            end
            ST_RALLY: begin
                if (left_exit) begin
                    state_d = (right_inc == WIN) ? ST_GAME_OVER : ST_SERVE;
                end else if (right_exit) begin
                    state_d = (left_inc == WIN) ? ST_GAME_OVER : ST_SERVE;
                end
            end
            ST_GAME_OVER: begin
                if (start_edge) state_d = ST_SERVE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and serve counter
    always_comb begin
        serve_cnt_d   = serve_cnt;
        left_score_d  = left_score_q;
        right_score_d = right_score_q;
        serve_dir_d   = serve_dir_q;
        winner_d      = winner_q;
        new_round_d   = (state_d == ST_SERVE) && (state != ST_SERVE);

        if (state != ST_SERVE) begin
            serve_cnt_d = '0;
        end else if (bus.frame_tick) begin
            serve_cnt_d = serve_done ? '0 : serve_cnt + CNT_W'(1);
        end

        case (state)
            ST_RALLY: begin
                if (left_exit) begin
                    right_score_d = right_inc;
                    serve_dir_d   = SIDE_LEFT;
                    if (right_inc == WIN) winner_d = SIDE_RIGHT;
                end else if (right_exit) begin
                    left_score_d = left_inc;
                    serve_dir_d  = SIDE_RIGHT;
                    if (left_inc == WIN) winner_d = SIDE_LEFT;
                end
            end
            ST_GAME_OVER: begin
                if (start_edge) begin
                    left_score_d  = '0;
                    right_score_d = '0;
                end
            end
            default: ;
        endcase
    end

`ifdef REFEREE_SPEEDUP_EN
    localparam int unsigned HIT_CNT_W = cnt_width(SPEEDUP_HITS);
    localparam logic [HIT_CNT_W-1:0] HIT_LAST = HIT_CNT_W'(SPEEDUP_HITS - 1);

    logic                 hit_any_q;
    logic [HIT_CNT_W-1:0] hit_cnt;
    logic [SPEED_W-1:0]   speed_q;

    // One speed step per SPEEDUP_HITS distinct paddle contacts within a round
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_any_q <= 1'b0;
            hit_cnt   <= '0;
            speed_q   <= '0;
        end else begin
            hit_any_q <= hit_left_q | hit_right_q;
            if (new_round_q) begin
                hit_cnt <= '0;
                speed_q <= '0;
            end else if ((hit_left_q | hit_right_q) && !hit_any_q) begin
                if (hit_cnt == HIT_LAST) begin
                    hit_cnt <= '0;
                    if (speed_q != '1) speed_q <= speed_q + SPEED_W'(1);
                end else begin
                    hit_cnt <= hit_cnt + HIT_CNT_W'(1);
                end
            end
        end
    end

    assign bus.speed_level = speed_q;
`else
    assign bus.speed_level = '0;
`endif

    assign bus.hit_left    = hit_left_q;
    assign bus.hit_right   = hit_right_q;
    assign bus.new_round   = new_round_q;
    assign bus.ball_run    = ball_run_q;
    assign bus.serve_dir   = serve_dir_q;
    assign bus.left_score  = left_score_q;
    assign bus.right_score = right_score_q;
    assign bus.game_over   = game_over_q;
    assign bus.winner      = winner_q;
endmodule

// File: tb/tb_pong_match_referee.sv
// Directed self-checking bench for pong_match_referee: hit-window vector table
// plus hand-written serve, scoring, win, restart and reset sequences.
module tb_pong_match_referee;
    localparam int unsigned SERVE_FRAMES = 60;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   nr_count;

    pong_match_referee_if #(.X_W(10), .SCORE_W(8)) bus ();

    pong_match_referee #(
        .X_W(10), .SCORE_W(8), .WIN_SCORE(11), .FIELD_W(640), .LEFT_PADDLE_X(10),
        .PADDLE_W(10), .PADDLE_H(80), .SERVE_FRAMES(SERVE_FRAMES), .SPEEDUP_HITS(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] bx;
        logic [9:0] by;
        logic [9:0] lpy;
        logic [9:0] rpy;
        logic       hl;
        logic       hr;
    } hit_vec_t;

    hit_vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic serve_out();
        bus.ball_x = 10'd320;
        repeat (SERVE_FRAMES - 1) tick();
        chk("serve_hold_ball_run", 32'(bus.ball_run), 32'd0);
        tick();
        chk("serve_release_ball_run", 32'(bus.ball_run), 32'd1);
    endtask

    // Right exit: left player scores
    task automatic score_left();
        bus.ball_x = 10'd600;
        tick();
        bus.ball_x = 10'd700;
        tick();
    endtask

    // Left exit (wrapped below 0): right player scores
    task automatic score_right();
        bus.ball_x = 10'd100;
        tick();
        bus.ball_x = 10'd1020;
        tick();
    endtask

    task automatic far_paddles();
        bus.ball_y         = 10'd0;
        bus.left_paddle_y  = 10'd500;
        bus.right_paddle_y = 10'd500;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        vecs[0]  = '{10'd5,   10'd240,  10'd200,  10'd500, 1'b1, 1'b0};
        vecs[1]  = '{10'd5,   10'd281,  10'd200,  10'd500, 1'b0, 1'b0};
        vecs[2]  = '{10'd5,   10'd280,  10'd200,  10'd500, 1'b1, 1'b0};
        vecs[3]  = '{10'd5,   10'd200,  10'd200,  10'd500, 1'b1, 1'b0};
        vecs[4]  = '{10'd5,   10'd199,  10'd200,  10'd500, 1'b0, 1'b0};
        vecs[5]  = '{10'd10,  10'd240,  10'd200,  10'd500, 1'b1, 1'b0};
        vecs[6]  = '{10'd11,  10'd240,  10'd200,  10'd500, 1'b0, 1'b0};
        vecs[7]  = '{10'd630, 10'd100,  10'd500,  10'd50,  1'b0, 1'b1};
        vecs[8]  = '{10'd629, 10'd100,  10'd500,  10'd50,  1'b0, 1'b0};
        vecs[9]  = '{10'd630, 10'd131,  10'd500,  10'd50,  1'b0, 1'b0};
        vecs[10] = '{10'd5,   10'd1020, 10'd1000, 10'd500, 1'b1, 1'b0};
        vecs[11] = '{10'd639, 10'd130,  10'd500,  10'd50,  1'b0, 1'b1};

        reset              = 1'b1;
        bus.frame_tick     = 1'b0;
        bus.ball_x         = 10'd320;
        bus.left_start     = 1'b0;
        bus.right_start    = 1'b0;
        far_paddles();
        step();
        step();

        chk("rst_new_round",   32'(bus.new_round),   32'd1);
        chk("rst_ball_run",    32'(bus.ball_run),    32'd0);
        chk("rst_left_score",  32'(bus.left_score),  32'd0);
        chk("rst_right_score", 32'(bus.right_score), 32'd0);
        chk("rst_game_over",   32'(bus.game_over),   32'd0);
        chk("rst_winner",      32'(bus.winner),      32'd0);
        chk("rst_serve_dir",   32'(bus.serve_dir),   32'd0);
        chk("rst_hits",        32'({bus.hit_left, bus.hit_right}), 32'd0);
        chk("rst_speed",       32'(bus.speed_level), 32'd0);

        reset = 1'b0;
        step();
        chk("idle_new_round", 32'(bus.new_round), 32'd0);

        // Held button: exactly one SERVE entry
        nr_count = 0;
        bus.right_start = 1'b1;
        repeat (200) begin
            step();
            if (bus.new_round) nr_count++;
        end
        bus.right_start = 1'b0;
        step();
        chk("held_start_one_serve", 32'(nr_count), 32'd1);

        // Start edge and paddle contact are ignored while serving
        bus.left_start    = 1'b1;
        bus.ball_x        = 10'd5;
        bus.ball_y        = 10'd240;
        bus.left_paddle_y = 10'd200;
        step();
        chk("serve_start_ignored", 32'(bus.new_round), 32'd0);
        chk("serve_no_hit",        32'(bus.hit_left),  32'd0);
        bus.left_start = 1'b0;
        step();
        far_paddles();
        serve_out();

        for (int i = 0; i < 12; i++) begin
            bus.ball_x         = vecs[i].bx;
            bus.ball_y         = vecs[i].by;
            bus.left_paddle_y  = vecs[i].lpy;
            bus.right_paddle_y = vecs[i].rpy;
            step();
            chk($sformatf("hit_left_v%0d", i),  32'(bus.hit_left),  32'(vecs[i].hl));
            chk($sformatf("hit_right_v%0d", i), 32'(bus.hit_right), 32'(vecs[i].hr));
        end
        bus.ball_x = 10'd320;
        far_paddles();
        step();

        score_right();
        chk("lexit_right_score", 32'(bus.right_score), 32'd1);
        chk("lexit_left_score",  32'(bus.left_score),  32'd0);
        chk("lexit_serve_dir",   32'(bus.serve_dir),   32'd0);
        chk("lexit_new_round",   32'(bus.new_round),   32'd1);
        chk("lexit_ball_run",    32'(bus.ball_run),    32'd0);
        step();
        chk("lexit_new_round_end", 32'(bus.new_round), 32'd0);

        // Left player runs to the win score
        for (int i = 1; i <= 11; i++) begin
            serve_out();
            score_left();
            if (i == 1) chk("rexit_serve_dir", 32'(bus.serve_dir), 32'd1);
            if (i == 10) begin
                chk("ten_left_score", 32'(bus.left_score), 32'd10);
                chk("ten_game_over",  32'(bus.game_over),  32'd0);
            end
        end
        chk("win_left_score",  32'(bus.left_score),  32'd11);
        chk("win_right_score", 32'(bus.right_score), 32'd1);
        chk("win_game_over",   32'(bus.game_over),   32'd1);
        chk("win_winner",      32'(bus.winner),      32'd0);
        chk("win_ball_run",    32'(bus.ball_run),    32'd0);
        chk("win_no_new_round", 32'(bus.new_round),  32'd0);

        bus.ball_x = 10'd320;
        repeat (SERVE_FRAMES + 5) tick();
        score_left();
        chk("over_exit_ignored", 32'(bus.left_score), 32'd11);
        chk("over_stays",        32'(bus.game_over),  32'd1);
        chk("over_no_run",       32'(bus.ball_run),   32'd0);

        bus.left_start = 1'b1;
        step();
        bus.left_start = 1'b0;
        chk("restart_left_score",  32'(bus.left_score),  32'd0);
        chk("restart_right_score", 32'(bus.right_score), 32'd0);
        chk("restart_new_round",   32'(bus.new_round),   32'd1);
        chk("restart_game_over",   32'(bus.game_over),   32'd0);
        step();

        // 5/7 then reset mid-rally
        for (int i = 0; i < 12; i++) begin
            serve_out();
            if (i < 5) score_left();
            else score_right();
        end
        serve_out();
        chk("mid_left_score",  32'(bus.left_score),  32'd5);
        chk("mid_right_score", 32'(bus.right_score), 32'd7);
        reset = 1'b1;
        step();
        chk("mid_rst_left",      32'(bus.left_score),  32'd0);
        chk("mid_rst_right",     32'(bus.right_score), 32'd0);
        chk("mid_rst_new_round", 32'(bus.new_round),   32'd1);
        chk("mid_rst_ball_run",  32'(bus.ball_run),    32'd0);
        reset = 1'b0;
        step();
        repeat (SERVE_FRAMES + 10) tick();
        chk("post_rst_idle", 32'(bus.ball_run), 32'd0);
        bus.right_start = 1'b1;
        step();
        chk("post_rst_start", 32'(bus.new_round), 32'd1);
        bus.right_start = 1'b0;
        step();
        serve_out();

        // Separate paddle contacts drive the speed steps
        bus.ball_y        = 10'd240;
        bus.left_paddle_y = 10'd200;
        for (int i = 0; i < 4; i++) begin
            bus.ball_x = 10'd5;
            step();
            bus.ball_x = 10'd320;
            step();
        end
`ifdef REFEREE_SPEEDUP_EN
        chk("speed_4_hits", 32'(bus.speed_level), 32'd1);
`else
        chk("speed_4_hits", 32'(bus.speed_level), 32'd0);
`endif
        for (int i = 0; i < 16; i++) begin
            bus.ball_x = 10'd5;
            step();
            bus.ball_x = 10'd320;
            step();
        end
`ifdef REFEREE_SPEEDUP_EN
        chk("speed_20_hits", 32'(bus.speed_level), 32'd3);
`else
        chk("speed_20_hits", 32'(bus.speed_level), 32'd0);
`endif
        far_paddles();
        score_left();
        step();
        chk("speed_point_clear", 32'(bus.speed_level), 32'd0);
        chk("speed_point_score", 32'(bus.left_score),  32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
